// File: rtl/rock_scheduler.sv
// -----------------------------------------------------------------------------
// rock_scheduler
//
// Rocking-motion sequencer between the path-finding decision logic and the
// cradle motor driver. It produces alternating forward/back half-periods,
// holds the current frequency and amplitude levels, and applies frequency-up,
// frequency-down and amplitude-down requests only at full-period ends. Every
// level change is followed by a settle interval of SETTLE full periods, during
// which requests are ignored. Levels persist across enable cycles; only reset
// restores them.
//
// Optional feature macro: ROCK_AMP_RESTORE_EN
//   When defined, the amplitude level climbs back by one towards A_INIT after
//   RESTORE_PERIODS consecutive period ends without an amplitude-down request.
//   When undefined, the amplitude level only ever decreases.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   enable       in   rocking request
//   fplus        in   frequency-up request (level)
//   fmin         in   frequency-down request (level)
//   amin         in   amplitude-down request (level)
//   drive        out  motor active (forward or back half)
//   phase        out  0 = forward half, 1 = back half
//   freq_level   out  current frequency level [FW]
//   amp_level    out  current amplitude level [AW]
//   period_tick  out  one-cycle pulse after each full-period end
//   settling     out  settle interval in progress
// -----------------------------------------------------------------------------
module rock_scheduler #(
    parameter int FW              = 3,
    parameter int AW              = 3,
    parameter int BASE_HALF       = 1000,
    parameter int STEP_HALF       = 100,
    parameter int SETTLE          = 2,
    parameter int F_INIT          = 0,
    parameter int A_INIT          = 4,
    parameter int RESTORE_PERIODS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          fplus,
    input  logic          fmin,
    input  logic          amin,
    output logic          drive,
    output logic          phase,
    output logic [FW-1:0] freq_level,
    output logic [AW-1:0] amp_level,
    output logic          period_tick,
    output logic          settling
);

    localparam int CW = $clog2(BASE_HALF + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [FW-1:0] FMAX = '1;

    // The shortest half (top frequency level) must still be at least one cycle,
    // and a settle interval of zero would let requests chain every period.
    if (BASE_HALF <= ((1 << FW) - 1) * STEP_HALF || SETTLE < 1 || RESTORE_PERIODS < 1) begin : g_bad_params
        $error("rock_scheduler: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_BACK = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] half_cnt;
    logic [CW-1:0] half_cnt_nxt;
    logic [FW-1:0] freq_nxt;
    logic [AW-1:0] amp_nxt;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_nxt;
    logic          half_end;
    logic          period_end;
    logic          lvl_change;

`ifdef ROCK_AMP_RESTORE_EN
    localparam int RW = $clog2(RESTORE_PERIODS + 1);
    logic [RW-1:0] rest_cnt;
    logic [RW-1:0] rest_nxt;
    logic [RW-1:0] rest_inc;
`endif

    // Counter load value for a half at frequency level f: L-1, so the counter
    // reads 0 in the last cycle of the half.
    function automatic logic [CW-1:0] half_load(input logic [FW-1:0] f);
        int len;
        len = BASE_HALF - int'(f) * STEP_HALF;
        return CW'(len - 1);
    endfunction

    assign half_end   = (state != S_IDLE) && (half_cnt == '0);
    assign period_end = (state == S_BACK) && (half_cnt == '0);

    // ---------------------------------------------------------------- levels
    always_comb begin
        freq_nxt   = freq_level;
        amp_nxt    = amp_level;
        settle_nxt = settle_cnt;
        lvl_change = 1'b0;
`ifdef ROCK_AMP_RESTORE_EN
        rest_nxt   = rest_cnt;
        rest_inc   = rest_cnt;
`endif
        if (period_end) begin
            if (settle_cnt != '0) begin
                settle_nxt = settle_cnt - 1'b1;
            end else begin
                // Saturated requests leave the level alone and are not a change.
                if (fplus && !fmin && freq_level != FMAX) begin
                    freq_nxt   = freq_level + 1'b1;
                    lvl_change = 1'b1;
                end else if (fmin && !fplus && freq_level != '0) begin
                    freq_nxt   = freq_level - 1'b1;
                    lvl_change = 1'b1;
                end
                if (amin && amp_level != '0) begin
                    amp_nxt    = amp_level - 1'b1;
                    lvl_change = 1'b1;
                end
                if (lvl_change) begin
                    settle_nxt = SW'(SETTLE);
                end
            end
`ifdef ROCK_AMP_RESTORE_EN
            // The restore count keeps running through settle intervals; only
            // the actual step back up waits for the settle counter to clear.
            if (amin) begin
                rest_nxt = '0;
            end else begin
                rest_inc = (rest_cnt == RW'(RESTORE_PERIODS)) ? rest_cnt : rest_cnt + 1'b1;
                rest_nxt = rest_inc;
                if (rest_inc == RW'(RESTORE_PERIODS) && amp_level < AW'(A_INIT) && settle_cnt == '0) begin
                    amp_nxt    = amp_level + 1'b1;
                    rest_nxt   = '0;
                    settle_nxt = SW'(SETTLE);
                end
            end
`endif
        end
    end

    // ---------------------------------------------------------- next state
    // The load uses freq_nxt so the forward half after a change already runs
    // at the new frequency.
    always_comb begin
        state_nxt    = state;
        half_cnt_nxt = half_cnt;
        case (state)
            S_IDLE: begin
                half_cnt_nxt = '0;
                if (enable) begin
                    state_nxt    = S_FWD;
                    half_cnt_nxt = half_load(freq_nxt);
                end
            end
            S_FWD, S_BACK: begin
                if (half_end) begin
                    if (enable) begin
                        state_nxt    = (state == S_FWD) ? S_BACK : S_FWD;
                        half_cnt_nxt = half_load(freq_nxt);
                    end else begin
                        state_nxt    = S_IDLE;
                        half_cnt_nxt = '0;
                    end
                end else begin
                    half_cnt_nxt = half_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                half_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            half_cnt <= '0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            freq_level  <= FW'(F_INIT);
            amp_level   <= AW'(A_INIT);
            settle_cnt  <= '0;
            period_tick <= 1'b0;
        end else begin
            freq_level  <= freq_nxt;
            amp_level   <= amp_nxt;
            settle_cnt  <= settle_nxt;
            period_tick <= period_end;
        end
    end

`ifdef ROCK_AMP_RESTORE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rest_cnt <= '0;
        end else begin
            rest_cnt <= rest_nxt;
        end
    end
`endif

    // ------------------------------------------------------------- outputs
    always_comb begin
        drive = 1'b0;
        phase = 1'b0;
        case (state)
            S_FWD:   drive = 1'b1;
            S_BACK: begin
                drive = 1'b1;
                phase = 1'b1;
            end
            default: ;
        endcase
    end

    assign settling = (settle_cnt != '0);

endmodule

// File: tb/tb_rock_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rock_scheduler
//
// Directed bench for rock_scheduler with BASE_HALF=20, STEP_HALF=2, SETTLE=2,
// F_INIT=0, A_INIT=4. A behavioural model tracks mode, elapsed cycles in the
// current half and the levels; every falling edge the DUT outputs are checked
// against it. Hand-computed literal checks at known cycle offsets pin the
// model. Define ROCK_AMP_RESTORE_EN for both files to exercise the restore path.
// -----------------------------------------------------------------------------
module tb_rock_scheduler;

    localparam int FW     = 3;
    localparam int AW     = 3;
    localparam int BASE   = 20;
    localparam int STEP   = 2;
    localparam int SETTLE = 2;
    localparam int F_INIT = 0;
    localparam int A_INIT = 4;
    localparam int RP     = 8;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic          fplus  = 1'b0;
    logic          fmin   = 1'b0;
    logic          amin   = 1'b0;
    logic          drive;
    logic          phase;
    logic [FW-1:0] freq_level;
    logic [AW-1:0] amp_level;
    logic          period_tick;
    logic          settling;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rock_scheduler #(
        .FW(FW), .AW(AW), .BASE_HALF(BASE), .STEP_HALF(STEP), .SETTLE(SETTLE),
        .F_INIT(F_INIT), .A_INIT(A_INIT), .RESTORE_PERIODS(RP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fplus(fplus), .fmin(fmin),
        .amin(amin), .drive(drive), .phase(phase), .freq_level(freq_level),
        .amp_level(amp_level), .period_tick(period_tick), .settling(settling)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    // mode: 0 idle, 1 forward, 2 back. el counts cycles already spent in the
    // current half; the half ends when el reaches len-1.
    typedef struct {
        int mode;
        int el;
        int len;
        int freq;
        int amp;
        int settle;
        int tick;
        int rest;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.el = 0; r.len = 0; r.freq = F_INIT; r.amp = A_INIT;
        r.settle = 0; r.tick = 0; r.rest = 0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input logic en,
                                          input logic fp, input logic fm, input logic am);
        model_t n;
        bit     changed;
        n = c;
        n.tick = 0;
        if (c.mode == 0) begin
            if (en) begin
                n.mode = 1;
                n.el   = 0;
                n.len  = BASE - c.freq * STEP;
            end
        end else if (c.el < c.len - 1) begin
            n.el = c.el + 1;
        end else begin
            if (c.mode == 2) begin
                n.tick = 1;
                if (c.settle > 0) begin
                    n.settle = c.settle - 1;
                end else begin
                    changed = 0;
                    if (fp && !fm && c.freq < (1 << FW) - 1) begin n.freq = c.freq + 1; changed = 1; end
                    if (fm && !fp && c.freq > 0)            begin n.freq = c.freq - 1; changed = 1; end
                    if (am && c.amp > 0)                    begin n.amp  = c.amp - 1;  changed = 1; end
                    if (changed) n.settle = SETTLE;
                end
`ifdef ROCK_AMP_RESTORE_EN
                if (am) begin
                    n.rest = 0;
                end else begin
                    n.rest = c.rest + 1;
                    if (n.rest >= RP && c.amp < A_INIT && c.settle == 0) begin
                        n.amp    = c.amp + 1;
                        n.rest   = 0;
                        n.settle = SETTLE;
                    end
                end
`endif
            end
            if (en) begin
                n.mode = (c.mode == 1) ? 2 : 1;
                n.el   = 0;
                n.len  = BASE - n.freq * STEP;
            end else begin
                n.mode = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_next(m, enable, fplus, fmin, amin);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if ($time > 2) begin
            chk("drive",       drive,       (m.mode != 0));
            chk("phase",       phase,       (m.mode == 2));
            chk("freq_level",  freq_level,  m.freq);
            chk("amp_level",   amp_level,   m.amp);
            chk("period_tick", period_tick, m.tick);
            chk("settling",    settling,    (m.settle != 0));
        end
    end

    // --------------------------------------------------------- stimulus
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; fplus = 1'b0; fmin = 1'b0; amin = 1'b0;
        reset  = 1'b0;
        adv(2);
        chk("lit_rst_drive", drive, 0);
        chk("lit_rst_freq",  freq_level, F_INIT);
        chk("lit_rst_amp",   amp_level, A_INIT);
        chk("lit_rst_settle", settling, 0);
        reset = 1'b1;
        adv(1);
    endtask

    initial begin
        #1 reset = 1'b0;
        adv(3);
        reset = 1'b1;
        adv(1);

        // Plain rocking: halves of 20, period ticks every 40.
        do_reset();
        enable = 1'b1;
        chk("lit_s1_drive_pre", drive, 0);
        adv(1);  chk("lit_s1_drive_e1", drive, 1); chk("lit_s1_phase_e1", phase, 0);
        adv(19); chk("lit_s1_phase_e20", phase, 0);
        adv(1);  chk("lit_s1_phase_e21", phase, 1);
        adv(19); chk("lit_s1_tick_e40", period_tick, 0);
        adv(1);  chk("lit_s1_tick_e41", period_tick, 1); chk("lit_s1_phase_e41", phase, 0);
                 chk("lit_s1_freq", freq_level, 0); chk("lit_s1_amp", amp_level, 4);
        adv(1);  chk("lit_s1_tick_e42", period_tick, 0);
        adv(39); chk("lit_s1_tick_e81", period_tick, 1);
        enable = 1'b0;
        adv(25);

        // fplus held: change, two ignored ends, change; halves 18 then 16.
        do_reset();
        enable = 1'b1; fplus = 1'b1;
        adv(41); chk("lit_s2_freq_e41", freq_level, 1); chk("lit_s2_settle_e41", settling, 1);
        adv(17); chk("lit_s2_phase_e58", phase, 0);
        adv(1);  chk("lit_s2_phase_e59", phase, 1);
        adv(18); chk("lit_s2_tick_e77", period_tick, 1); chk("lit_s2_freq_e77", freq_level, 1);
                 chk("lit_s2_settle_e77", settling, 1);
        adv(36); chk("lit_s2_freq_e113", freq_level, 1); chk("lit_s2_settle_e113", settling, 0);
        adv(36); chk("lit_s2_freq_e149", freq_level, 2); chk("lit_model_freq_e149", m.freq, 2);
        adv(15); chk("lit_s2_phase_e164", phase, 0);
        adv(1);  chk("lit_s2_phase_e165", phase, 1);
        fplus = 1'b0; enable = 1'b0;
        adv(40);

        // fplus and fmin together: no change, no settle.
        do_reset();
        enable = 1'b1; fplus = 1'b1; fmin = 1'b1;
        adv(200); chk("lit_s3_freq", freq_level, 0); chk("lit_s3_settle", settling, 0);
        adv(1);   chk("lit_s3_tick_e201", period_tick, 1); chk("lit_s3_settle_e201", settling, 0);
        fplus = 1'b0; fmin = 1'b0; enable = 1'b0;
        adv(45);

        // amin with saturated fmin: amplitude steps every third period end.
        do_reset();
        enable = 1'b1; amin = 1'b1; fmin = 1'b1;
        adv(41);  chk("lit_s4_amp_e41", amp_level, 3); chk("lit_s4_settle_e41", settling, 1);
                  chk("lit_s4_freq_e41", freq_level, 0);
        adv(119); chk("lit_s4_amp_e160", amp_level, 3);
        adv(1);   chk("lit_s4_amp_e161", amp_level, 2); chk("lit_model_amp_e161", m.amp, 2);
        amin = 1'b0; fmin = 1'b0; enable = 1'b0;
        adv(45);

        // Enable drop/re-assert, drop to idle, then reset mid-back.
        do_reset();
        enable = 1'b1; fplus = 1'b1; amin = 1'b1;
        adv(41); chk("lit_s5_freq_e41", freq_level, 1); chk("lit_s5_amp_e41", amp_level, 3);
        fplus = 1'b0; amin = 1'b0;
        adv(40); enable = 1'b0;
        adv(4);  enable = 1'b1;
        adv(10); chk("lit_s5_phase_e95", phase, 1); chk("lit_s5_drive_e95", drive, 1);
        adv(25); enable = 1'b0;
        adv(10); chk("lit_s5_drive_e130", drive, 1);
        adv(1);  chk("lit_s5_drive_e131", drive, 0); chk("lit_s5_phase_e131", phase, 0);
                 chk("lit_s5_freq_e131", freq_level, 1); chk("lit_s5_amp_e131", amp_level, 3);
        adv(10); chk("lit_s5_idle_drive", drive, 0); chk("lit_s5_idle_freq", freq_level, 1);
        enable = 1'b1;
        adv(25); chk("lit_s5_phase_midback", phase, 1);
        #2 reset = 1'b0;
        #1;
        chk("lit_s5_async_drive", drive, 0); chk("lit_s5_async_phase", phase, 0);
        chk("lit_s5_async_freq", freq_level, 0); chk("lit_s5_async_amp", amp_level, 4);
        chk("lit_s5_async_settle", settling, 0); chk("lit_s5_async_tick", period_tick, 0);
        adv(1);  enable = 1'b0;
        adv(1);  reset = 1'b1;
        adv(5);  chk("lit_s5_wait_enable", drive, 0);
        enable = 1'b1;
        adv(1);  chk("lit_s5_restart", drive, 1);
        enable = 1'b0;
        adv(25);

`ifdef ROCK_AMP_RESTORE_EN
        // Amplitude climbs back after eight quiet period ends, then stops at A_INIT.
        do_reset();
        enable = 1'b1; amin = 1'b1;
        adv(41);  chk("lit_s6_amp_e41", amp_level, 3);
        amin = 1'b0;
        adv(319); chk("lit_s6_amp_e360", amp_level, 3);
        adv(1);   chk("lit_s6_amp_e361", amp_level, 4); chk("lit_s6_settle_e361", settling, 1);
        adv(400); chk("lit_s6_amp_hold", amp_level, 4);
        enable = 1'b0;
        adv(25);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rock_scheduler.md
# rock_scheduler

Rocking-motion sequencer sitting between the path-finding decision logic and the cradle motor driver. Generates forward/back half-periods, holds the current frequency and amplitude levels, and applies the frequency-up (`fplus`), frequency-down (`fmin`) and amplitude-down (`amin`) requests only at full-period boundaries, with a settle interval after every change. Levels persist across enable cycles; only reset restores them.

## Interface
- `FW`, 3: frequency level width; max level `2^FW-1`.
- `AW`, 3: amplitude level width; max level `2^AW-1`.
- `BASE_HALF`, 1000: half-period length in cycles at frequency level 0.
- `STEP_HALF`, 100: half-period reduction per frequency level; `BASE_HALF > (2^FW-1)*STEP_HALF` is required.
- `SETTLE`, 2: full periods during which requests are ignored after a change; must be at least 1.
- `F_INIT`, 0: frequency level after reset.
- `A_INIT`, 4: amplitude level after reset.
- `RESTORE_PERIODS`, 8: used only with `ROCK_AMP_RESTORE_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  rocking request.
- `fplus`  in  1  frequency-up request, level, synchronous to `clk`.
- `fmin`  in  1  frequency-down request, level.
- `amin`  in  1  amplitude-down request, level.
- `drive`  out  1  motor active (state FWD or BACK).
- `phase`  out  1  0 = forward half, 1 = back half.
- `freq_level`  out  FW  current frequency level.
- `amp_level`  out  AW  current amplitude level.
- `period_tick`  out  1  one-cycle pulse at each full-period end.
- `settling`  out  1  settle counter nonzero.

## Operation
- States:
  - IDLE: `drive=0`, `phase=0`.
  - FWD: `drive=1`, `phase=0`.
  - BACK: `drive=1`, `phase=1`.
- Half length: `L = BASE_HALF - freq_level*STEP_HALF`.
  - Half counter is loaded with `L-1` on entering FWD or BACK and decrements each cycle.
  - The boundary cycle is the cycle in which the counter equals 0.
- IDLE -> FWD on the first cycle `enable=1`; the counter is loaded in that transition.
- At a FWD boundary:
  - `enable=1`: go to BACK.
  - `enable=0`: go to IDLE.
- At a BACK boundary (period end):
  - `enable=1`: go to FWD; `enable=0`: go to IDLE.
  - `period_tick` pulses in both cases.
  - Request evaluation follows.
- Request evaluation, performed only on BACK-boundary cycles and only when the settle counter is 0:
  - `fplus & ~fmin` and `freq_level < 2^FW-1`: `freq_level` +1.
  - `fmin & ~fplus` and `freq_level > 0`: `freq_level` -1.
  - `fplus & fmin`: frequency unchanged.
  - `amin` and `amp_level > 0`: `amp_level` -1. This is independent of the frequency decision.
  - If any level changed: settle counter = `SETTLE`.
- Saturated requests (`fplus` at max, `fmin` at 0, `amin` at 0) are not a change and do not start a settle interval.
- If the settle counter is nonzero at a BACK boundary, it decrements and all requests are ignored.
- Requests on non-boundary cycles are ignored entirely.
- Levels and the settle counter hold while in IDLE.

## Timing
- Reset values (asynchronous):
  - state IDLE; `drive=0`; `phase=0`.
  - `freq_level=F_INIT`; `amp_level=A_INIT`.
  - `period_tick=0`; `settling=0`; half counter 0; settle counter 0.
  - Restore counter 0 (only with `ROCK_AMP_RESTORE_EN`).
- All outputs are registered. Level changes, `period_tick`, and `drive`/`phase` updates are visible in the cycle after the boundary cycle.
- The FWD half following a frequency change uses the updated level, i.e. the next-state value feeds the load.
- `enable` deasserted mid-half takes effect only at the next half boundary. Re-asserting `enable` before that boundary cancels the stop.
- Reset asserted mid-half aborts immediately to the reset values. The first FWD after reset release starts no earlier than the first rising edge with `enable=1`.

## Configuration
- `ROCK_AMP_RESTORE_EN` defined:
  - A restore counter counts consecutive BACK-boundary cycles with `amin=0`.
  - `amin=1` at a boundary clears it.
  - On reaching `RESTORE_PERIODS`, if `amp_level < A_INIT` and the settle counter is 0: `amp_level` +1, restore counter cleared, settle counter = `SETTLE`.
- `ROCK_AMP_RESTORE_EN` undefined:
  - No restore counter.
  - `amp_level` only decreases; only reset restores it.

## Test plan
Parameters for all scenarios: `BASE_HALF=20`, `STEP_HALF=2`, `SETTLE=2`, `F_INIT=0`, `A_INIT=4`.
- Reset then `enable=1`, no requests -> `drive` rises one cycle later; `phase` toggles every 20 cycles; `period_tick` every 40 cycles; levels stay 0/4.
- `fplus=1` held -> `freq_level` 0->1 at the 1st period end; ignored at the 2nd and 3rd (`settling=1`); 1->2 at the 4th; halves become 18, then 16 cycles.
- `fplus=fmin=1` held 5 periods -> `freq_level` stays 0; `settling` never asserts.
- `amin` held with `fmin` at `freq_level=0` -> `amp_level` 4->3->2 on every third period end; `freq_level` stays 0.
- `enable` dropped mid-FWD -> BACK is skipped; IDLE at the FWD boundary; `drive=0`; levels held. `reset` pulsed mid-BACK -> immediate return to reset values.
- With `ROCK_AMP_RESTORE_EN` and `RESTORE_PERIODS=8`: `amp_level=3`, `amin=0` -> rises to 4 at the 8th period end, then no further rise.
